axis_frame_fifo: RTL

Parametrised AXI4-Stream FIFO, successor to the plain FWFT byte FIFO in the UART/AES datapath. It adds a frame (store-and-forward) mode so that only complete packets reach the consumer, which the AES block sinks need for whole 16-byte blocks. It also adds drop-on-oversize and drop-when-full policies, committed-depth reporting and per-frame status pulses. It sits between the UART RX deframer and the AES core input, and between the AES output and UART TX.

---
 rtl/axis_frame_fifo_if.sv | 22 ++
 rtl/axis_frame_fifo.sv | 137 +++++++++++++
 2 files changed

// File: rtl/axis_frame_fifo_if.sv
// AXI4-Stream bundle shared by the UART/AES datapath blocks.
// Carries tdata/tkeep/tlast with a valid/ready handshake.
interface my_axis_if #(
    parameter int DATA_W = 8,
    parameter int KEEP_W = (DATA_W + 7) / 8
);
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport master (
        output tdata, tkeep, tlast, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tlast, tvalid,
        output tready
    );
endinterface

// File: rtl/axis_frame_fifo.sv
// AXI4-Stream FIFO with optional store-and-forward frame mode,
// oversize/full frame dropping and depth/frame status reporting.
module axis_frame_fifo #(
    parameter int DEPTH          = 64,
    parameter int DATA_W         = 8,
    parameter int KEEP_W         = (DATA_W + 7) / 8,
    parameter int FRAME_FIFO     = 1,
    parameter int DROP_OVERSIZE  = 1,
    parameter int DROP_WHEN_FULL = 0
) (
    input  logic                     Clk,
    input  logic                     Rst,
    my_axis_if.slave                 s_axis,
    my_axis_if.master                m_axis,
    output logic [$clog2(DEPTH):0]   StatusDepth,
    output logic [$clog2(DEPTH):0]   StatusDepthCommit,
    output logic                     StatusOverflow,
    output logic                     StatusBadFrame,
    output logic                     StatusGoodFrame
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int MW = 1 + KEEP_W + DATA_W;

    typedef enum logic {
        ST_NORM,
        ST_DROP
    } state_t;

    state_t          state, state_n;
    logic [PW-1:0]   wr_cur, wr_cur_n;
    logic [PW-1:0]   wr_com, wr_com_n;
    logic [PW-1:0]   rd_ptr, rd_ptr_n;
    logic [MW-1:0]   mem [DEPTH];
    logic [MW-1:0]   rd_word;
    logic            full, oversize, trig;
    logic            s_rdy, wr_en;
    logic            good_n, bad_n, ovf_n;

    assign full     = (wr_cur - rd_ptr) == PW'(DEPTH);
    assign oversize = (DROP_OVERSIZE != 0)
                   && ((wr_cur - wr_com) == PW'(DEPTH));

    assign s_axis.tready = s_rdy;
    assign m_axis.tvalid = (wr_com != rd_ptr);
    assign rd_word       = mem[rd_ptr[AW-1:0]];
    assign m_axis.tlast  = rd_word[MW-1];
    assign m_axis.tkeep  = rd_word[MW-2 -: KEEP_W];
    assign m_axis.tdata  = rd_word[DATA_W-1:0];

    assign StatusDepth       = wr_cur - rd_ptr;
    assign StatusDepthCommit = wr_com - rd_ptr;

    always_comb begin
        state_n  = state;
        wr_cur_n = wr_cur;
        wr_com_n = wr_com;
        rd_ptr_n = rd_ptr;
        s_rdy    = 1'b1;
        trig     = 1'b0;
        wr_en    = 1'b0;
        good_n   = 1'b0;
        bad_n    = 1'b0;
        ovf_n    = 1'b0;
        if (FRAME_FIFO == 0) begin
            s_rdy = !full;
            wr_en = s_axis.tvalid && !full;
            ovf_n = s_axis.tvalid && full;
            if (wr_en) begin
                wr_cur_n = wr_cur + PW'(1);
            end
            good_n   = wr_en && s_axis.tlast;
            wr_com_n = wr_cur_n;
        end else begin
            unique case (state)
                ST_NORM: begin
                    // Oversize keeps tready up so a runaway frame drains.
                    s_rdy = (DROP_WHEN_FULL != 0) || !full || oversize;
                    trig  = s_axis.tvalid
                         && (oversize || ((DROP_WHEN_FULL != 0) && full));
                    if (trig) begin
                        if (s_axis.tlast) begin
                            wr_cur_n = wr_com;
                            bad_n    = 1'b1;
                        end else begin
                            state_n = ST_DROP;
                        end
                    end else if (s_axis.tvalid && s_rdy) begin
                        wr_en    = 1'b1;
                        wr_cur_n = wr_cur + PW'(1);
                        if (s_axis.tlast) begin
                            wr_com_n = wr_cur + PW'(1);
                            good_n   = 1'b1;
                        end
                    end
                end
                ST_DROP: begin
                    s_rdy = 1'b1;
                    if (s_axis.tvalid && s_axis.tlast) begin
                        wr_cur_n = wr_com;
                        bad_n    = 1'b1;
                        state_n  = ST_NORM;
                    end
                end
            endcase
        end
        if (m_axis.tvalid && m_axis.tready) begin
            rd_ptr_n = rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state           <= ST_NORM;
            wr_cur          <= '0;
            wr_com          <= '0;
            rd_ptr          <= '0;
            StatusOverflow  <= 1'b0;
            StatusBadFrame  <= 1'b0;
            StatusGoodFrame <= 1'b0;
        end else begin
            state           <= state_n;
            wr_cur          <= wr_cur_n;
            wr_com          <= wr_com_n;
            rd_ptr          <= rd_ptr_n;
            StatusOverflow  <= ovf_n;
            StatusBadFrame  <= bad_n;
            StatusGoodFrame <= good_n;
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[wr_cur[AW-1:0]] <= {s_axis.tlast, s_axis.tkeep, s_axis.tdata};
        end
    end
endmodule
